// File: rtl/serial_queue_bridge.sv
// rtl/serial_queue_bridge.sv - single-clock serial deserializer feeding a circular word queue
//
// Bits arrive MSB first on data_in, qualified by write_in on deserializer ticks.
// A completed word is held until a queue tick can enqueue it. The consumer pops
// words with dequeue_in on queue ticks. Both tick rates come from clock-enable
// counters on the single clock.
//
// Ports:
//   clock         sole clock, rising edge
//   reset         synchronous, active-high
//   data_in       serial data bit, MSB first
//   write_in      bit-valid qualifier, sampled on deserializer ticks
//   dequeue_in    pop request, sampled on queue ticks
//   status_out    1 = accepting bits, 0 = holding a completed word
//   data_out      last popped word
//   len_out       queue occupancy, 0..DEPTH
//   overflow_out  sticky: a held word waited a queue tick on a full queue
//   underflow_out one-cycle pulse after a pop of an empty queue
module serial_queue_bridge #(
    parameter int DATA_W  = 8,
    parameter int DEPTH   = 8,
    parameter int DES_DIV = 10,
    parameter int Q_DIV   = 100
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       data_in,
    input  logic                       write_in,
    input  logic                       dequeue_in,
    output logic                       status_out,
    output logic [DATA_W-1:0]          data_out,
    output logic [$clog2(DEPTH+1)-1:0] len_out,
    output logic                       overflow_out,
    output logic                       underflow_out
);

    localparam int LW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int DW = (DES_DIV > 1) ? $clog2(DES_DIV) : 1;
    localparam int QW = (Q_DIV > 1) ? $clog2(Q_DIV) : 1;
    localparam int BW = $clog2(DATA_W + 1);

    typedef enum logic {RECV, HOLD} state_t;

    state_t            state;
    state_t            state_next;
    logic [DW-1:0]     des_cnt;
    logic [QW-1:0]     q_cnt;
    logic              des_tick;
    logic              q_tick;
    logic [DATA_W-1:0] shreg;
    logic [BW-1:0]     bit_cnt;
    logic              capture;
    logic              last_bit;
    logic              pop;
    logic              empty_pop;
    logic              full;
    logic              ack;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [PW-1:0]     head;
    logic [PW-1:0]     tail;

    function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // Tick counters: each tick is the cycle on which its counter sits at DIV-1.
    assign des_tick = (des_cnt == DW'(DES_DIV - 1));
    assign q_tick   = (q_cnt == QW'(Q_DIV - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            des_cnt <= '0;
            q_cnt   <= '0;
        end else begin
            des_cnt <= des_tick ? '0 : des_cnt + DW'(1);
            q_cnt   <= q_tick ? '0 : q_cnt + QW'(1);
        end
    end

    assign capture   = (state == RECV) && des_tick && write_in;
    assign last_bit  = capture && (bit_cnt == BW'(DATA_W - 1));
    assign full      = (len_out == LW'(DEPTH));
    assign pop       = q_tick && dequeue_in && (len_out != '0);
    assign empty_pop = q_tick && dequeue_in && (len_out == '0);
    // A pop in the same tick frees a slot, so a full queue can still accept.
    // On an empty queue the pop underflows and the enqueue proceeds normally.
    assign ack       = q_tick && (state == HOLD) && (!full || pop);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= RECV;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        status_out = (state == RECV);
        case (state)
            RECV: if (last_bit) state_next = HOLD;
            HOLD: if (ack)      state_next = RECV;
            default:            state_next = RECV;
        endcase
    end

    // The bit count restarts on the last bit, so returning from HOLD sees 0.
    always_ff @(posedge clock) begin
        if (reset) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (capture) begin
            shreg   <= {shreg[DATA_W-2:0], data_in};
            bit_cnt <= last_bit ? '0 : bit_cnt + BW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (ack) begin
            mem[tail] <= shreg;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head          <= '0;
            tail          <= '0;
            len_out       <= '0;
            data_out      <= '0;
            overflow_out  <= 1'b0;
            underflow_out <= 1'b0;
        end else begin
            if (ack) begin
                tail <= inc_ptr(tail);
            end
            if (pop) begin
                data_out <= mem[head];
                head     <= inc_ptr(head);
            end
            case ({ack, pop})
                2'b10:   len_out <= len_out + LW'(1);
                2'b01:   len_out <= len_out - LW'(1);
                default: len_out <= len_out;
            endcase
            underflow_out <= empty_pop;
            if (q_tick && (state == HOLD) && !ack) begin
                overflow_out <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_serial_queue_bridge.sv
// tb/tb_serial_queue_bridge.sv - self-checking bench for serial_queue_bridge
module tb_serial_queue_bridge;

    localparam int DATA_W  = 8;
    localparam int DEPTH   = 4;
    localparam int DES_DIV = 2;
    localparam int Q_DIV   = 4;

    logic                       clock;
    logic                       reset;
    logic                       data_in;
    logic                       write_in;
    logic                       dequeue_in;
    logic                       status_out;
    logic [DATA_W-1:0]          data_out;
    logic [$clog2(DEPTH+1)-1:0] len_out;
    logic                       overflow_out;
    logic                       underflow_out;

    serial_queue_bridge #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .DES_DIV(DES_DIV),
        .Q_DIV  (Q_DIV)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .data_in      (data_in),
        .write_in     (write_in),
        .dequeue_in   (dequeue_in),
        .status_out   (status_out),
        .data_out     (data_out),
        .len_out      (len_out),
        .overflow_out (overflow_out),
        .underflow_out(underflow_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference model: cycle index since reset decides the ticks, a queue
    // holds stored words, and a flag plus word stand for the held word.
    int          mk;
    bit          model_valid;
    int          m_nbits;
    logic [7:0]  m_word;
    bit          m_held;
    logic [7:0]  m_held_word;
    logic [7:0]  m_q[$];
    logic [7:0]  m_data;
    bit          m_ovf;
    bit          m_unf;

    initial begin
        model_valid = 0;
        mk = 0;
        forever begin
            @(negedge clock);
            if (reset) begin
                mk = 0;
                m_nbits = 0;
                m_word = '0;
                m_held = 0;
                m_held_word = '0;
                m_q.delete();
                m_data = '0;
                m_ovf = 0;
                m_unf = 0;
                model_valid = 1;
            end else if (model_valid) begin
                bit dt, qt, was_held, pop_ok, enq;
                dt = (mk % DES_DIV) == DES_DIV - 1;
                qt = (mk % Q_DIV) == Q_DIV - 1;
                mk++;
                was_held = m_held;
                pop_ok = qt && dequeue_in && (m_q.size() > 0);
                m_unf  = qt && dequeue_in && (m_q.size() == 0);
                enq    = qt && was_held && ((m_q.size() < DEPTH) || pop_ok);
                if (qt && was_held && !enq) m_ovf = 1;
                if (pop_ok) m_data = m_q.pop_front();
                if (enq) begin
                    m_q.push_back(m_held_word);
                    m_held = 0;
                end
                if (dt && !was_held && write_in) begin
                    m_word = (m_word << 1) | {7'd0, data_in};
                    m_nbits++;
                    if (m_nbits == DATA_W) begin
                        m_held = 1;
                        m_held_word = m_word;
                        m_nbits = 0;
                        m_word = '0;
                    end
                end
            end
            if (model_valid) begin
                chk("cyc_status", status_out, !m_held);
                chk("cyc_data", data_out, m_data);
                chk("cyc_len", len_out, m_q.size());
                chk("cyc_overflow", overflow_out, m_ovf);
                chk("cyc_underflow", underflow_out, m_unf);
            end
        end
    end

    task automatic next_cyc();
        @(negedge clock);
        #1;
    endtask

    task automatic send_bit(input logic b);
        bit hit;
        hit = 0;
        data_in = b;
        write_in = 1'b1;
        for (int i = 0; i < 2 * DES_DIV + 2 && !hit; i++) begin
            hit = (mk % DES_DIV) == DES_DIV - 1;
            next_cyc();
        end
        write_in = 1'b0;
    endtask

    task automatic wait_status();
        for (int i = 0; i < 4 * Q_DIV + 4 && status_out !== 1'b1; i++) next_cyc();
        chk("wait_status", status_out, 1);
    endtask

    task automatic send_word(input logic [7:0] w);
        wait_status();
        for (int i = 7; i >= 0; i--) send_bit(w[i]);
    endtask

    task automatic wait_len(input int n);
        for (int i = 0; i < 3 * Q_DIV + 4 && len_out != n; i++) next_cyc();
        chk("wait_len", len_out, n);
    endtask

    task automatic do_pop();
        bit hit;
        hit = 0;
        dequeue_in = 1'b1;
        for (int i = 0; i < 2 * Q_DIV + 2 && !hit; i++) begin
            hit = (mk % Q_DIV) == Q_DIV - 1;
            next_cyc();
        end
        dequeue_in = 1'b0;
    endtask

    logic [7:0] w;
    logic [7:0] last_w;
    logic [7:0] gap_word;

    initial begin
        reset = 1'b1;
        data_in = 1'b0;
        write_in = 1'b0;
        dequeue_in = 1'b0;
        next_cyc();
        next_cyc();
        reset = 1'b0;
        chk("rst_status", status_out, 1);
        chk("rst_data", data_out, 0);
        chk("rst_len", len_out, 0);
        chk("rst_overflow", overflow_out, 0);
        chk("rst_underflow", underflow_out, 0);

        // Single word
        send_word(8'hA5);
        chk("single_hold_status", status_out, 0);
        wait_len(1);
        chk("single_enq_status", status_out, 1);
        do_pop();
        chk("single_pop_data", data_out, 8'hA5);
        chk("single_pop_len", len_out, 0);

        // Fill and backpressure
        for (int i = 1; i <= 5; i++) send_word(8'(i));
        repeat (Q_DIV + 1) next_cyc();
        chk("fill_len", len_out, 4);
        chk("fill_status", status_out, 0);
        chk("fill_overflow", overflow_out, 1);
        do_pop();
        chk("fill_pop_data", data_out, 8'h01);
        chk("fill_pop_len", len_out, 4);
        chk("fill_pop_status", status_out, 1);
        for (int i = 2; i <= 5; i++) begin
            do_pop();
            chk("drain_data", data_out, i);
        end
        chk("drain_len", len_out, 0);

        // Wrap-around, alternating push/pop
        for (int i = 0; i < 10; i++) begin
            w = 8'(i * 37 + 3);
            send_word(w);
            wait_len(1);
            do_pop();
            chk("wrap_data", data_out, w);
            chk("wrap_len", len_out, 0);
        end
        last_w = 8'h50;

        // Underflow
        do_pop();
        chk("unf_pulse", underflow_out, 1);
        chk("unf_data", data_out, last_w);
        chk("unf_len", len_out, 0);
        next_cyc();
        chk("unf_pulse_end", underflow_out, 0);

        // Gapped bits
        gap_word = 8'h3C;
        for (int i = 7; i >= 4; i--) send_bit(gap_word[i]);
        data_in = 1'b1;
        repeat (3 * DES_DIV) next_cyc();
        for (int i = 3; i >= 0; i--) send_bit(gap_word[i]);
        wait_len(1);
        do_pop();
        chk("gap_data", data_out, 8'h3C);

        // Reset mid-word
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        reset = 1'b1;
        next_cyc();
        reset = 1'b0;
        chk("rst2_status", status_out, 1);
        chk("rst2_len", len_out, 0);
        chk("rst2_overflow", overflow_out, 0);
        chk("rst2_data", data_out, 0);
        send_word(8'hFF);
        wait_len(1);
        do_pop();
        chk("rst2_pop_data", data_out, 8'hFF);
        chk("rst2_pop_overflow", overflow_out, 0);

        repeat (4) next_cyc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
